// File: rtl/sprite_renderer.sv
// Plot-side renderer for one player and two enemy squares.
// Each service erases the sprite's previous square, then draws it at its new position.
module sprite_renderer #(
  parameter int         PLAYER_WIDTH  = 3,
  parameter logic [2:0] PLAYER_COLOUR = 3'b111,
  parameter logic [2:0] ENEMY_COLOUR  = 3'b100,
  parameter logic [2:0] BG_COLOUR     = 3'b000,
  parameter int         SCREEN_W      = 160,
  parameter int         SCREEN_H      = 120
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       player_move,
  input  logic [7:0] playerX,
  input  logic [6:0] playerY,
  input  logic       enemy0_move,
  input  logic [7:0] enemy0X,
  input  logic [6:0] enemy0Y,
  input  logic [2:0] enemy0_width,
  input  logic       enemy1_move,
  input  logic [7:0] enemy1X,
  input  logic [6:0] enemy1Y,
  input  logic [2:0] enemy1_width,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy
);

  localparam logic [2:0] PW = 3'(PLAYER_WIDTH);
  localparam logic [8:0] SW = 9'(SCREEN_W);
  localparam logic [7:0] SH = 8'(SCREEN_H);

  typedef enum logic [1:0] {IDLE, LOAD, ERASE, DRAW} state_t;
  state_t state, next_state;

  logic [2:0] pending;
  logic [7:0] old_x [0:2];
  logic [6:0] old_y [0:2];
  logic [2:0] old_w [0:2];
  logic [2:0] old_valid;

  logic [1:0] sel;
  logic [7:0] new_x, erase_x;
  logic [6:0] new_y, erase_y;
  logic [2:0] new_w, erase_w;
  logic [2:0] i, j;

  logic [1:0] pick_sel, fin_sel;
  logic [7:0] pick_x, fin_x, base_x;
  logic [6:0] pick_y, fin_y, base_y;
  logic [2:0] pick_w, fin_w, cur_w;
  logic [8:0] sum_x;
  logic [7:0] sum_y;
  logic       i_last, j_last, last_px, finish;
  logic [2:0] clr_mask;

  // Fixed priority: player, then enemy 0, then enemy 1.
  always_comb begin
    pick_sel = 2'd2;
    pick_x   = enemy1X;
    pick_y   = enemy1Y;
    pick_w   = enemy1_width;
    if (pending[0]) begin
      pick_sel = 2'd0;
      pick_x   = playerX;
      pick_y   = playerY;
      pick_w   = PW;
    end else if (pending[1]) begin
      pick_sel = 2'd1;
      pick_x   = enemy0X;
      pick_y   = enemy0Y;
      pick_w   = enemy0_width;
    end
  end

  always_comb begin
    cur_w   = (state == ERASE) ? erase_w : new_w;
    base_x  = (state == ERASE) ? erase_x : new_x;
    base_y  = (state == ERASE) ? erase_y : new_y;
    i_last  = (i == cur_w - 3'd1);
    j_last  = (j == cur_w - 3'd1);
    last_px = i_last && j_last;
    sum_x   = {1'b0, base_x} + {6'd0, i};
    sum_y   = {1'b0, base_y} + {5'd0, j};
    fin_sel = (state == LOAD) ? pick_sel : sel;
    fin_x   = (state == LOAD) ? pick_x : new_x;
    fin_y   = (state == LOAD) ? pick_y : new_y;
    fin_w   = (state == LOAD) ? pick_w : new_w;
    clr_mask = (state == LOAD) ? (3'b001 << pick_sel) : 3'b000;
  end

  always_comb begin
    next_state = state;
    finish     = 1'b0;
    case (state)
      IDLE: if (|pending) next_state = LOAD;
      LOAD: begin
        if (old_valid[pick_sel] && old_w[pick_sel] != 3'd0) next_state = ERASE;
        else if (pick_w != 3'd0) next_state = DRAW;
        else begin
          next_state = IDLE;
          finish     = 1'b1;
        end
      end
      ERASE: begin
        if (last_px) begin
          if (new_w != 3'd0) next_state = DRAW;
          else begin
            next_state = IDLE;
            finish     = 1'b1;
          end
        end
      end
      DRAW: begin
        if (last_px) begin
          next_state = IDLE;
          finish     = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  // Datapath: pending flags, snapshots, scan counters and registered pixel outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pending   <= 3'b111;
      old_valid <= 3'b000;
      for (int k = 0; k < 3; k++) begin
        old_x[k] <= 8'd0;
        old_y[k] <= 7'd0;
        old_w[k] <= 3'd0;
      end
      sel     <= 2'd0;
      new_x   <= 8'd0;
      new_y   <= 7'd0;
      new_w   <= 3'd0;
      erase_x <= 8'd0;
      erase_y <= 7'd0;
      erase_w <= 3'd0;
      i       <= 3'd0;
      j       <= 3'd0;
      vga_x   <= 8'd0;
      vga_y   <= 7'd0;
      colour  <= BG_COLOUR;
      plot    <= 1'b0;
    end else begin
      plot    <= 1'b0;
      pending <= (pending & ~clr_mask) | {enemy1_move, enemy0_move, player_move};
      case (state)
        LOAD: begin
          sel     <= pick_sel;
          new_x   <= pick_x;
          new_y   <= pick_y;
          new_w   <= pick_w;
          erase_x <= old_x[pick_sel];
          erase_y <= old_y[pick_sel];
          erase_w <= old_w[pick_sel];
          i       <= 3'd0;
          j       <= 3'd0;
        end
        ERASE, DRAW: begin
          vga_x  <= sum_x[7:0];
          vga_y  <= sum_y[6:0];
          colour <= (state == ERASE) ? BG_COLOUR :
                    (sel == 2'd0)    ? PLAYER_COLOUR : ENEMY_COLOUR;
          plot   <= (sum_x < SW) && (sum_y < SH);
          if (last_px) begin
            i <= 3'd0;
            j <= 3'd0;
          end else if (i_last) begin
            i <= 3'd0;
            j <= j + 3'd1;
          end else begin
            i <= i + 3'd1;
          end
        end
        default: ;
      endcase
      if (finish) begin
        old_x[fin_sel]     <= fin_x;
        old_y[fin_sel]     <= fin_y;
        old_w[fin_sel]     <= fin_w;
        old_valid[fin_sel] <= (fin_w != 3'd0);
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_sprite_renderer.sv
// Scoreboard bench for sprite_renderer: expected pixels are queued by the
// stimulus and popped by a monitor whenever plot is high.
module tb_sprite_renderer;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic       player_move, enemy0_move, enemy1_move;
  logic [7:0] playerX, enemy0X, enemy1X;
  logic [6:0] playerY, enemy0Y, enemy1Y;
  logic [2:0] enemy0_width, enemy1_width;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] colour;
  logic       plot, busy;

  int   compared = 0;
  int   failed   = 0;
  int   plot_count = 0;
  int   cyc = 0;
  pix_t exp_q[$];
  int   plot_cyc[$];

  sprite_renderer dut (
    .clk(clk), .resetn(resetn),
    .player_move(player_move), .playerX(playerX), .playerY(playerY),
    .enemy0_move(enemy0_move), .enemy0X(enemy0X), .enemy0Y(enemy0Y), .enemy0_width(enemy0_width),
    .enemy1_move(enemy1_move), .enemy1X(enemy1X), .enemy1Y(enemy1Y), .enemy1_width(enemy1_width),
    .vga_x(vga_x), .vga_y(vga_y), .colour(colour), .plot(plot), .busy(busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every plotted pixel is matched against the head of the queue.
  initial forever begin
    @(negedge clk);
    if (plot === 1'b1) begin
      plot_count++;
      plot_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        compared++;
        failed++;
        $display("[TB] FAIL unexpected_plot: actual x=%0d y=%0d c=%0b required no plot", vga_x, vga_y, colour);
      end else begin
        pix_t e;
        e = exp_q.pop_front();
        checkOutput("pixel", {14'd0, vga_x, vga_y, colour}, {14'd0, e});
      end
    end
  end

  task automatic push_square(input int x, input int y, input int w, input logic [2:0] c);
    for (int jj = 0; jj < w; jj++)
      for (int ii = 0; ii < w; ii++)
        if (x + ii < 160 && y + jj < 120)
          exp_q.push_back('{x: 8'(x + ii), y: 7'(y + jj), c: c});
  endtask

  task automatic applyStimulus(input logic p, input logic e0, input logic e1);
    @(posedge clk); #1;
    player_move = p; enemy0_move = e0; enemy1_move = e1;
    @(posedge clk); #1;
    player_move = 1'b0; enemy0_move = 1'b0; enemy1_move = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(posedge clk); #1;
      if (!busy && exp_q.size() == 0) done = 1'b1;
    end
    checkOutput({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    checkOutput({name, "_busy_low"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_plots(input string name, input int n);
    bit done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(posedge clk); #1;
      if (plot_count >= n) done = 1'b1;
    end
    if (!done) begin
      compared++;
      failed++;
      $display("[TB] FAIL %s_timeout: actual plots=%0d required=%0d", name, plot_count, n);
    end
  endtask

  task automatic check_gap(input string name, input int idx, input int gap);
    int d;
    d = (plot_cyc.size() > idx && idx > 0) ? plot_cyc[idx] - plot_cyc[idx-1] : -1;
    checkOutput(name, 32'(d), 32'(gap));
  endtask

  task automatic check_span(input string name, input int a, input int b, input int span);
    int d;
    d = (plot_cyc.size() > b) ? plot_cyc[b] - plot_cyc[a] : -1;
    checkOutput(name, 32'(d), 32'(span));
  endtask

  initial begin
    resetn = 1'b0;
    player_move = 1'b0; enemy0_move = 1'b0; enemy1_move = 1'b0;
    playerX = 8'd80; playerY = 7'd115;
    enemy0X = 8'd10; enemy0Y = 7'd20; enemy0_width = 3'd4;
    enemy1X = 8'd50; enemy1Y = 7'd60; enemy1_width = 3'd2;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_plot", {31'd0, plot}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_vga_x", {24'd0, vga_x}, 32'd0);
    checkOutput("reset_vga_y", {25'd0, vga_y}, 32'd0);
    checkOutput("reset_colour", {29'd0, colour}, 32'd0);

    // Initial draw after reset: no erase pixels.
    push_square(80, 115, 3, 3'b111);
    push_square(10, 20, 4, 3'b100);
    push_square(50, 60, 2, 3'b100);
    plot_cyc.delete();
    resetn = 1'b1;
    wait_idle("initial");
    checkOutput("initial_plot_total", 32'(plot_cyc.size()), 32'd29);

    // Player one column left.
    repeat (3) @(posedge clk); #1;
    plot_cyc.delete();
    playerX = 8'd79;
    push_square(80, 115, 3, 3'b000);
    push_square(79, 115, 3, 3'b111);
    applyStimulus(1'b1, 1'b0, 1'b0);
    wait_plots("move_busy", plot_count + 1);
    checkOutput("move_busy_high", {31'd0, busy}, 32'd1);
    wait_idle("move");
    checkOutput("move_plot_total", 32'(plot_cyc.size()), 32'd18);
    check_span("move_contiguous", 0, 17, 17);

    // Simultaneous player and enemy1 pulses.
    repeat (3) @(posedge clk); #1;
    plot_cyc.delete();
    playerX = 8'd78; enemy1X = 8'd52; enemy1Y = 7'd61;
    push_square(79, 115, 3, 3'b000);
    push_square(78, 115, 3, 3'b111);
    push_square(50, 60, 2, 3'b000);
    push_square(52, 61, 2, 3'b100);
    applyStimulus(1'b1, 1'b0, 1'b1);
    wait_idle("prio");
    check_span("prio_player_span", 0, 17, 17);
    check_gap("prio_gap", 18, 3);
    check_span("prio_enemy1_span", 18, 25, 7);

    // Enemy0 into the bottom-right corner: clipped draw.
    repeat (3) @(posedge clk); #1;
    plot_cyc.delete();
    enemy0X = 8'd158; enemy0Y = 7'd118; enemy0_width = 3'd3;
    push_square(10, 20, 4, 3'b000);
    push_square(158, 118, 3, 3'b100);
    applyStimulus(1'b0, 1'b1, 1'b0);
    wait_idle("clip");
    checkOutput("clip_plot_total", 32'(plot_cyc.size()), 32'd20);
    check_gap("clip_gap_a", 16, 1);
    check_gap("clip_gap_b", 17, 1);
    check_gap("clip_gap_c", 18, 2);
    check_gap("clip_gap_d", 19, 1);

    // Re-pulse during DRAW; input change mid-service is ignored.
    repeat (3) @(posedge clk); #1;
    playerX = 8'd77;
    push_square(78, 115, 3, 3'b000);
    push_square(77, 115, 3, 3'b111);
    push_square(77, 115, 3, 3'b000);
    push_square(76, 115, 3, 3'b111);
    applyStimulus(1'b1, 1'b0, 1'b0);
    wait_plots("repulse", plot_count + 11);
    playerX = 8'd76;
    applyStimulus(1'b1, 1'b0, 1'b0);
    wait_idle("repulse");

    // Reset in the middle of an erase.
    repeat (3) @(posedge clk); #1;
    playerX = 8'd75;
    push_square(76, 115, 3, 3'b000);
    push_square(75, 115, 3, 3'b111);
    applyStimulus(1'b1, 1'b0, 1'b0);
    wait_plots("abort", plot_count + 3);
    resetn = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_plot_low", {31'd0, plot}, 32'd0);
    checkOutput("abort_busy_low", {31'd0, busy}, 32'd0);
    exp_q.delete();
    push_square(75, 115, 3, 3'b111);
    push_square(158, 118, 3, 3'b100);
    push_square(52, 61, 2, 3'b100);
    repeat (2) @(posedge clk); #1;
    plot_cyc.delete();
    resetn = 1'b1;
    wait_idle("redraw");
    checkOutput("redraw_plot_total", 32'(plot_cyc.size()), 32'd17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
